// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] ERR_WORD          = 32'h0000_0000;

    // Limit is one past the last byte, held in 33 bits so the top of the map cannot wrap.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [32:0] limit);
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one combinational read port, no reset.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Preload write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end else begin
            mem_q[waddr_i] <= mem_q[waddr_i];
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with range/alignment checking over a preloadable array.
module imem_responder
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_inst,
    output logic                           resp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
    input  logic [31:0]                    ld_data
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          resp_valid_q;
    logic [31:0]   resp_inst_q;
    logic          resp_err_q;
    logic [31:0]   pend_inst_q;
    logic          pend_err_q;

    logic          fault_s;
    logic [AW-1:0] rd_idx_s;
    logic [31:0]   rd_data_s;
    logic [31:0]   fetch_inst_s;
    logic          req_ready_s;
    logic          accept_s;
    logic          resp_hs_s;

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .we_i   (ld_en),
        .waddr_i(ld_idx),
        .wdata_i(ld_data),
        .raddr_i(rd_idx_s),
        .rdata_o(rd_data_s)
    );

    // Address decode, handshake qualification and the word captured on accept.
    always_comb begin
        fault_s      = addr_fault(req_addr, BASE_ADDR, LIMIT);
        rd_idx_s     = AW'((req_addr - BASE_ADDR) >> 2);
        fetch_inst_s = fault_s ? ERR_WORD : rd_data_s;
        req_ready_s  = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
        accept_s     = req_valid && req_ready_s;
        resp_hs_s    = resp_valid_q && resp_ready;
    end

    // Request/response FSM; an accept in RESP is only possible alongside the response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= ERR_WORD;
            resp_err_q   <= 1'b0;
            pend_inst_q  <= ERR_WORD;
            pend_err_q   <= 1'b0;
        end else if (accept_s) begin
            if (LATENCY == 1) begin
                state_q      <= RESP;
                resp_valid_q <= 1'b1;
                resp_inst_q  <= fetch_inst_s;
                resp_err_q   <= fault_s;
            end else begin
                state_q      <= WAIT;
                cnt_q        <= LAT - 4'd1;
                resp_valid_q <= 1'b0;
                pend_inst_q  <= fetch_inst_s;
                pend_err_q   <= fault_s;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q      <= RESP;
                        cnt_q        <= 4'd0;
                        resp_valid_q <= 1'b1;
                        resp_inst_q  <= pend_inst_q;
                        resp_err_q   <= pend_err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_hs_s) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end else begin
                        resp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= 4'd0;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_q;
    assign resp_inst  = resp_inst_q;
    assign resp_err   = resp_err_q;

endmodule
